// File: rtl/sram_arb_pkg.sv
// Shared constants, state type and CPU window mapping for the SRAM slot arbiter.
package sram_arb_pkg;

  localparam logic [2:0] SLOT_VID_ADDR = 3'd1;
  localparam logic [2:0] SLOT_VID_CAP  = 3'd3;
  localparam logic [2:0] SLOT_CPU_ADDR = 3'd4;
  localparam logic [2:0] SLOT_CPU_CAP  = 3'd6;
  localparam logic [2:0] SLOT_LAST     = 3'd7;

  localparam logic [1:0]  WIN_BASE   = 2'b10;
  localparam int unsigned WIN_PAGE_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    VID_ADDR,
    VID_RD,
    VID_CAP,
    CPU_ADDR,
    CPU_ACC,
    CPU_CAP
  } arb_state_t;

  // $8000-$BFFF is a 16K window into the upper 64K, selected by the page bits
  function automatic logic [16:0] cpu_map(input logic [15:0] ad,
                                          input logic [WIN_PAGE_W-1:0] pg);
    if (ad[15:14] == WIN_BASE) return {1'b1, pg, ad[13:0]};
    else                       return {1'b0, ad};
  endfunction

endpackage

// File: rtl/sram_arb_slotgen.sv
// Slot counter (8 clk_in cycles per CPU bus cycle) and sys_clk generation.
// slot_nxt exposes the slot about to start so callers can register outputs
// that are valid for the whole of that slot.
module sram_arb_slotgen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk_in,
  input  logic       b_reset,
  output logic [2:0] slot,
  output logic [2:0] slot_nxt,
  output logic       sys_clk
);

  logic [2:0] slot_q, slot_d;
  logic       run_q, run_d;
  logic       sys_clk_q, sys_clk_d;

  // The first edge after reset release starts slot 0 with sys_clk high;
  // afterwards the counter free-runs and wraps 7->0.
  always_comb begin
    run_d     = 1'b1;
    slot_d    = run_q ? slot_q + 3'd1 : '0;
    sys_clk_d = (slot_d < 3'(CLK_DIV));
  end

  // Counter and sys_clk registers
  always_ff @(posedge clk_in or negedge b_reset) begin
    if (!b_reset) begin
      slot_q    <= '0;
      run_q     <= 1'b0;
      sys_clk_q <= 1'b0;
    end else begin
      slot_q    <= slot_d;
      run_q     <= run_d;
      sys_clk_q <= sys_clk_d;
    end
  end

  assign slot     = slot_q;
  assign slot_nxt = slot_d;
  assign sys_clk  = sys_clk_q;

endmodule

// File: rtl/sram_arb.sv
// SRAM time-slot arbiter: video read in slots 1-3, CPU access in slots 4-7.
// Build option SRAM_ARB_PARK_EN: drop CS2 in slots with no active access.
module sram_arb #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned PAGE_W  = 5
) (
  input  logic              clk_in,
  input  logic              b_reset,
  output logic              sys_clk,
  input  logic [15:0]       cpu_ad,
  input  logic [7:0]        cpu_do,
  input  logic              cpu_rw,
  input  logic              cpu_cs,
  input  logic [PAGE_W-1:0] page,
  output logic [7:0]        cpu_di,
  input  logic              vid_req,
  input  logic [15:0]       vid_ad,
  output logic              vid_ack,
  output logic [7:0]        vid_data,
  output logic [16:0]       SRAM_AD,
  inout  wire  [7:0]        SRAM_DQ,
  output logic              SRAM_WE_n,
  output logic              SRAM_OE_n,
  output logic              SRAM_CS2
);
  import sram_arb_pkg::*;

  logic [2:0] slot, slot_nxt;
  logic       unused_page;

  assign unused_page = ^{page, slot};

  sram_arb_slotgen #(.CLK_DIV(CLK_DIV)) u_slotgen (
    .clk_in   (clk_in),
    .b_reset  (b_reset),
    .slot     (slot),
    .slot_nxt (slot_nxt),
    .sys_clk  (sys_clk)
  );

  arb_state_t  state_q, state_d;
  logic [16:0] ad_q, ad_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        cs2_q, cs2_d;
  logic        dq_oe_q, dq_oe_d;
  logic [7:0]  dout_q, dout_d;
  logic        wr_q, wr_d;
  logic        ack_q, ack_d;
  logic [7:0]  vid_data_q, vid_data_d;
  logic [7:0]  cpu_di_q, cpu_di_d;

  // Next-slot decode: every strobe is registered so it is clean for the whole slot.
  // Captures happen on the edge leaving the last OE_n-low slot.
  always_comb begin
    state_d    = IDLE;
    ad_d       = ad_q;
    oe_n_d     = 1'b1;
    we_n_d     = 1'b1;
    dq_oe_d    = 1'b0;
    dout_d     = dout_q;
    wr_d       = wr_q;
    ack_d      = 1'b0;
    vid_data_d = vid_data_q;
    cpu_di_d   = cpu_di_q;
    case (slot_nxt)
      SLOT_VID_ADDR: if (vid_req) begin
        state_d = VID_ADDR;
        ad_d    = {1'b0, vid_ad};
        oe_n_d  = 1'b0;
      end
      3'd2: if (state_q == VID_ADDR) begin
        state_d = VID_RD;
        oe_n_d  = 1'b0;
      end
      SLOT_VID_CAP: if (state_q == VID_RD) begin
        state_d    = VID_CAP;
        vid_data_d = SRAM_DQ;
        ack_d      = 1'b1;
      end
      SLOT_CPU_ADDR: if (cpu_cs) begin
        state_d = CPU_ADDR;
        ad_d    = cpu_map(cpu_ad, page[WIN_PAGE_W-1:0]);
        wr_d    = ~cpu_rw;
        dout_d  = cpu_do;
        oe_n_d  = ~cpu_rw;
        dq_oe_d = ~cpu_rw;
      end
      3'd5: if (state_q == CPU_ADDR) begin
        state_d = CPU_ACC;
        oe_n_d  = wr_q;
        we_n_d  = ~wr_q;
        dq_oe_d = wr_q;
      end
      SLOT_CPU_CAP: if (state_q == CPU_ACC) begin
        state_d = CPU_CAP;
        oe_n_d  = wr_q;
        we_n_d  = ~wr_q;
        dq_oe_d = wr_q;
      end
      SLOT_LAST: if (state_q == CPU_CAP) begin
        state_d = CPU_ACC;
        dq_oe_d = wr_q;
        if (!wr_q) cpu_di_d = SRAM_DQ;
      end
      default: ;
    endcase
`ifdef SRAM_ARB_PARK_EN
    cs2_d = (state_d != IDLE);
`else
    cs2_d = 1'b1;
`endif
  end

  // Strobe FSM and data registers; async reset kills any strobe immediately
  always_ff @(posedge clk_in or negedge b_reset) begin
    if (!b_reset) begin
      state_q    <= IDLE;
      ad_q       <= '0;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      cs2_q      <= 1'b0;
      dq_oe_q    <= 1'b0;
      dout_q     <= '0;
      wr_q       <= 1'b0;
      ack_q      <= 1'b0;
      vid_data_q <= '0;
      cpu_di_q   <= '1;
    end else begin
      state_q    <= state_d;
      ad_q       <= ad_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      cs2_q      <= cs2_d;
      dq_oe_q    <= dq_oe_d;
      dout_q     <= dout_d;
      wr_q       <= wr_d;
      ack_q      <= ack_d;
      vid_data_q <= vid_data_d;
      cpu_di_q   <= cpu_di_d;
    end
  end

  assign SRAM_DQ   = dq_oe_q ? dout_q : 'z;
  assign SRAM_AD   = ad_q;
  assign SRAM_WE_n = we_n_q;
  assign SRAM_OE_n = oe_n_q;
  assign SRAM_CS2  = cs2_q;
  assign vid_ack   = ack_q;
  assign vid_data  = vid_data_q;
  assign cpu_di    = cpu_di_q;

endmodule
